// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
// Shared constants, the cipher mode enum and character-class helpers for the
// Vigenere stream cipher.
// Build option: CIPHER_DIGIT_EN -- when defined, ASCII digits are keyed
// characters (rotated mod 10 and advancing the key index); when undefined
// they pass through like any other non-alphabetic byte.
// ---------------------------------------------------------------------------
package cipher_pkg;

  localparam int ALPHA_SIZE = 26;
  localparam int DIGIT_SIZE = 10;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;  // 'Z'
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;  // 'z'
  localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;  // '0'
  localparam logic [7:0] ASCII_DIGIT_9 = 8'h39;  // '9'

  typedef enum logic {
    CIPH_ENC = 1'b0,
    CIPH_DEC = 1'b1
  } cipher_mode_e;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_DIGIT_0) && (c <= ASCII_DIGIT_9);
  endfunction

  // A keyed character is one that is rotated and consumes a key position.
  function automatic logic is_keyed_char(input logic [7:0] c);
`ifdef CIPHER_DIGIT_EN
    return is_upper(c) || is_lower(c) || is_digit(c);
`else
    return is_upper(c) || is_lower(c);
`endif
  endfunction

endpackage

// File: rtl/cipher_char_shift.sv
// ---------------------------------------------------------------------------
// cipher_char_shift
// Purely combinational single-character rotate. Letters rotate mod 26 within
// their own case; with CIPHER_DIGIT_EN defined, digits rotate mod 10. All
// other bytes, and any bits above bit 7, pass through unchanged.
// Ports:
//   src_char  in   DATA_W  character to transform
//   shift     in   5       rotate amount (any value 0..31 is reduced)
//   mode      in   enum    CIPH_ENC adds the shift, CIPH_DEC subtracts it
//   dst_char  out  DATA_W  transformed character
// ---------------------------------------------------------------------------
module cipher_char_shift
  import cipher_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] src_char,
  input  logic [4:0]        shift,
  input  cipher_mode_e      mode,
  output logic [DATA_W-1:0] dst_char
);

  // Rotate an in-range offset by s (s < size) modulo size. Decrypt adds size
  // before subtracting so the intermediate never goes negative.
  function automatic logic [4:0] rot_mod(input logic [4:0] off,
                                         input logic [4:0] s,
                                         input logic [4:0] size,
                                         input cipher_mode_e m);
    logic [5:0] t;
    if (m == CIPH_ENC) t = {1'b0, off} + {1'b0, s};
    else               t = {1'b0, off} + {1'b0, size} - {1'b0, s};
    if (t >= {1'b0, size}) t = t - {1'b0, size};
    return t[4:0];
  endfunction

  logic [7:0] lo;
  logic [4:0] s_alpha;
  logic [4:0] off;
  logic [4:0] rot;
`ifdef CIPHER_DIGIT_EN
  logic [4:0] s_digit;
`endif

  always_comb begin
    dst_char = src_char;
    lo       = src_char[7:0];
    off      = '0;
    rot      = '0;
    s_alpha  = (shift >= 5'(ALPHA_SIZE)) ? shift - 5'(ALPHA_SIZE) : shift;
`ifdef CIPHER_DIGIT_EN
    // Two conditional subtracts cover the whole 0..31 range for mod 10.
    s_digit = shift;
    if (s_digit >= 5'd20) s_digit = s_digit - 5'd20;
    if (s_digit >= 5'd10) s_digit = s_digit - 5'd10;
`endif
    if (is_upper(lo)) begin
      off           = 5'(lo - ASCII_UPPER_A);
      rot           = rot_mod(off, s_alpha, 5'(ALPHA_SIZE), mode);
      dst_char[7:0] = ASCII_UPPER_A + {3'b000, rot};
    end else if (is_lower(lo)) begin
      off           = 5'(lo - ASCII_LOWER_A);
      rot           = rot_mod(off, s_alpha, 5'(ALPHA_SIZE), mode);
      dst_char[7:0] = ASCII_LOWER_A + {3'b000, rot};
    end
`ifdef CIPHER_DIGIT_EN
    else if (is_digit(lo)) begin
      off           = 5'(lo - ASCII_DIGIT_0);
      rot           = rot_mod(off, s_digit, 5'(DIGIT_SIZE), mode);
      dst_char[7:0] = ASCII_DIGIT_0 + {3'b000, rot};
    end
`endif
  end

endmodule

// File: rtl/vigenere_stream_cipher.sv
// ---------------------------------------------------------------------------
// vigenere_stream_cipher
// Byte-wide streaming Vigenere engine with a programmable key of up to
// KEY_LEN_MAX shifts, encrypt/decrypt per character and valid/ready flow
// control with a single output register (latency 1, full throughput).
// Build option: CIPHER_DIGIT_EN -- also rotates '0'..'9' mod 10.
// Ports:
//   CLOCK_50             system clock, rising edge
//   reset                synchronous active-high reset
//   cfg_we/idx/shift     key register write (shift reduced mod 26)
//   key_len              active key length (0 -> 1, clamped to KEY_LEN_MAX)
//   mode                 0 encrypt, 1 decrypt, sampled on accept
//   in_valid/ready/data/last    input stream
//   out_valid/ready/data/last   output stream
//   key_pos              current key index (debug)
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | output register empty, out_valid low
// ST_FULL  | output register holds a character, out_valid high
// ---------------------------------------------------------------------------
module vigenere_stream_cipher
  import cipher_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int KEY_LEN_MAX = 8,
  parameter int IDX_W       = (KEY_LEN_MAX > 1) ? $clog2(KEY_LEN_MAX) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [4:0]        cfg_shift,
  input  logic [IDX_W:0]    key_len,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [IDX_W-1:0]  key_pos
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [IDX_W:0] LEN_ONE = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W + 1)'(KEY_LEN_MAX);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [4:0]        key_q [KEY_LEN_MAX];
  logic [IDX_W-1:0]  pos_q;
  logic [IDX_W:0]    eff_len;
  logic [IDX_W:0]    pos_inc;
  logic [4:0]        cur_shift;
  logic [DATA_W-1:0] shifted;
  logic              accept;
  logic              transfer;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;
  assign key_pos   = pos_q;

  always_comb begin
    if (key_len == '0)          eff_len = LEN_ONE;
    else if (key_len > LEN_MAX) eff_len = LEN_MAX;
    else                        eff_len = key_len;
  end

  // Reading the registered key means a same-cycle cfg write is only seen by
  // the following character.
  assign cur_shift = key_q[pos_q];
  assign pos_inc   = {1'b0, pos_q} + LEN_ONE;

  cipher_char_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .src_char (in_data),
    .shift    (cur_shift),
    .mode     (cipher_mode_e'(mode)),
    .dst_char (shifted)
  );

  // Key register file.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < KEY_LEN_MAX; i++) key_q[i] <= '0;
    end else if (cfg_we && (int'(cfg_idx) < KEY_LEN_MAX)) begin
      key_q[cfg_idx] <= (cfg_shift >= 5'(ALPHA_SIZE)) ?
                        cfg_shift - 5'(ALPHA_SIZE) : cfg_shift;
    end
  end

  // Key index: end-of-message wins, then advance on keyed characters, and a
  // shrunken key_len pulls an out-of-range index back to 0.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pos_q <= '0;
    end else if (accept && in_last) begin
      pos_q <= '0;
    end else if (accept && is_keyed_char(in_data[7:0])) begin
      pos_q <= (pos_inc >= eff_len) ? '0 : pos_inc[IDX_W-1:0];
    end else if ({1'b0, pos_q} >= eff_len) begin
      pos_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept)               state_d = ST_FULL;
      ST_FULL:  if (transfer && !accept)  state_d = ST_EMPTY;
      default:                            state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data <= shifted;
        out_last <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
module tb_vigenere_stream_cipher;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [4:0] cfg_shift = '0;
  logic [3:0] key_len = 4'd1;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] key_pos;

  vigenere_stream_cipher #(.DATA_W(8), .KEY_LEN_MAX(8)) dut (
    .CLOCK_50 (CLOCK_50), .reset (reset),
    .cfg_we (cfg_we), .cfg_idx (cfg_idx), .cfg_shift (cfg_shift),
    .key_len (key_len), .mode (mode),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .in_last (in_last),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_last (out_last), .key_pos (key_pos)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc++;

  typedef struct { logic [7:0] data; logic last; } exp_t;
  exp_t sb[$];

  int m_key[8];
  int m_pos = 0;
  int sink_mode = 0;  // 0 always ready, 1 random, 2 held low

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_eff();
    if (key_len == 0) return 1;
    if (key_len > 8) return 8;
    return int'(key_len);
  endfunction

  function automatic bit m_keyed(input int c);
    bit k = (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
`ifdef CIPHER_DIGIT_EN
    k = k || (c >= 48 && c <= 57);
`endif
    return k;
  endfunction

  function automatic int m_cipher(input int c, input int s, input bit dec);
    int base, size, r;
    if (c >= 65 && c <= 90)       begin base = 65; size = 26; end
    else if (c >= 97 && c <= 122) begin base = 97; size = 26; end
`ifdef CIPHER_DIGIT_EN
    else if (c >= 48 && c <= 57)  begin base = 48; size = 10; end
`endif
    else return c;
    r = dec ? (c - base - s) : (c - base + s);
    r = ((r % size) + size) % size;
    return base + r;
  endfunction

  // ---------------- sink ----------------
  initial forever begin
    @(posedge CLOCK_50); #1;
    case (sink_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic prev_last = 0;
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), int'(prev_data));
          check("hold_last", int'(out_last), int'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e = sb.pop_front();
            check("out_data", int'(out_data), int'(e.data));
            check("out_last", int'(out_last), int'(e.last));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input int c, input bit last, input bit dec,
                      input bit use_exp, input int exp_c,
                      input bit do_cfg, input int ci, input int cs);
    bit accepted = 0;
    int waited = 0;
    exp_t e;
    in_valid = 1'b1; in_data = 8'(c); in_last = last; mode = dec;
    if (do_cfg) begin cfg_we = 1'b1; cfg_idx = 3'(ci); cfg_shift = 5'(cs); end
    while (!accepted && waited < 50) begin
      @(negedge CLOCK_50);
      if (in_ready) begin
        accepted = 1;
        e.data = use_exp ? 8'(exp_c) : 8'(m_cipher(c, m_key[m_pos], dec));
        e.last = last;
        sb.push_back(e);
        if (last) m_pos = 0;
        else if (m_keyed(c)) m_pos = (m_pos + 1) % m_eff();
      end
      if (do_cfg && waited == 0) m_key[ci] = cs % 26;
      @(posedge CLOCK_50); #1;
      cfg_we = 1'b0;
      waited++;
    end
    if (!accepted) check("accept_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic send_str(input string s, input string x, input bit dec, input bit last);
    for (int i = 0; i < s.len(); i++)
      send(int'(s[i]), last && (i == s.len() - 1), dec, 1, int'(x[i]), 0, 0, 0);
  endtask

  task automatic set_key(input int idx, input int val);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_shift = 5'(val);
    @(posedge CLOCK_50); #1;
    cfg_we = 1'b0;
    m_key[idx] = val % 26;
  endtask

  task automatic set_len(input int l);
    key_len = 4'(l);
    if (m_pos >= m_eff()) m_pos = 0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge CLOCK_50); #1; n++;
    end
    check("drain_timeout", int'(sb.size() == 0 && !out_valid), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, r, c;
    for (int i = 0; i < 8; i++) m_key[i] = 0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_key_pos", int'(key_pos), 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;

    // Caesar, full throughput
    set_key(0, 3); set_len(1);
    c0 = cyc;
    send_str("HELLO", "KHOOR", 0, 0);
    check("hello_cycles", cyc - c0, 5);
    drain();

    // Vigenere LEMON both directions
    set_key(0, 11); set_key(1, 4); set_key(2, 12); set_key(3, 14); set_key(4, 13);
    set_len(5);
    send_str("ATTACKATDAWN", "LXFOPVEFRNHR", 0, 1);
    send_str("LXFOPVEFRNHR", "ATTACKATDAWN", 1, 1);
    drain();

    // wrap and case
    set_key(0, 3); set_len(1);
    send_str("zY", "cB", 0, 1);
    set_key(0, 1);
    send_str("a", "z", 1, 1);

    // non-alpha leaves key_pos alone
    set_key(0, 1); set_key(1, 2); set_len(2);
    send(int'("A"), 0, 0, 1, int'("B"), 0, 0, 0);
    check("kpos_after_A", int'(key_pos), 1);
    send(int'(" "), 0, 0, 1, int'(" "), 0, 0, 0);
    check("kpos_after_space", int'(key_pos), 1);
    send(int'("B"), 1, 0, 1, int'("D"), 0, 0, 0);
    drain();

    // backpressure
    sink_mode = 2;
    @(posedge CLOCK_50); #1;
    fork
      send_str("WXYZ", "XZZB", 0, 1);
      begin
        @(negedge CLOCK_50);
        repeat (3) begin
          @(negedge CLOCK_50);
          check("bp_in_ready", int'(in_ready), 0);
        end
        sink_mode = 0;
      end
    join
    drain();

    // in_last restarts the key
    set_key(0, 5); set_key(1, 7);
    send_str("AB", "FI", 0, 1);
    send_str("A", "F", 0, 0);
    check("kpos_wrap_len2", int'(key_pos), 1);
    send_str("A", "H", 0, 1);
    check("kpos_after_last", int'(key_pos), 0);

    // cfg value 30 is stored as 4; a same-cycle write is not yet visible
    set_key(0, 30); set_len(1);
    send_str("A", "E", 0, 1);
    send(int'("A"), 1, 0, 1, int'("E"), 1, 0, 10);
    send_str("A", "K", 0, 1);
    drain();

    // shrinking key_len pulls key_pos back to 0
    set_key(0, 1); set_key(1, 2); set_key(2, 3); set_key(3, 4);
    set_len(4);
    send_str("aaa", "bcd", 0, 0);
    check("kpos_before_shrink", int'(key_pos), 3);
    set_len(2);
    @(negedge CLOCK_50);
    check("kpos_after_shrink", int'(key_pos), 0);
    @(posedge CLOCK_50); #1;
    send_str("aa", "bc", 0, 1);
    drain();

    // randomized traffic against the model
    sink_mode = 1;
    for (int i = 0; i < 8; i++) set_key(i, $urandom_range(0, 31));
    for (int blk = 0; blk < 12; blk++) begin
      set_len($urandom_range(0, 15));
      for (int n = 0; n < 30; n++) begin
        r = $urandom_range(0, 3);
        case (r)
          0: c = $urandom_range(65, 90);
          1: c = $urandom_range(97, 122);
          2: c = $urandom_range(48, 57);
          default: c = $urandom_range(32, 126);
        endcase
        send(c, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 0, 0,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 7), $urandom_range(0, 31));
        if ($urandom_range(0, 4) == 0) begin @(posedge CLOCK_50); #1; end
      end
    end
    sink_mode = 0;
    drain();

    // reset while a character is held
    set_key(0, 9); set_len(1);
    sink_mode = 2;
    @(posedge CLOCK_50); #1;
    send(int'("Q"), 0, 0, 1, int'("Z"), 0, 0, 0);
    check("pre_rst_valid", int'(out_valid), 1);
    reset = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_key_pos", int'(key_pos), 0);
    sb.delete();
    for (int i = 0; i < 8; i++) m_key[i] = 0;
    m_pos = 0;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    sink_mode = 0;
    send_str("Q", "Q", 0, 1);
    drain();
    set_key(0, 3);
`ifdef CIPHER_DIGIT_EN
    send_str("8", "1", 0, 1);
`else
    send_str("8", "8", 0, 1);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
